// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg: ALU ctrl codes, MIPS opcode/funct encodings and the issue bundle.
// Rev 1.0
// ============================================================================
package alu_pkg;

  localparam int ALU_XLEN      = 32;
  localparam int ALU_REG_IDX_W = 5;

  localparam logic [3:0] CTRL_SLL = 4'b0000;
  localparam logic [3:0] CTRL_SRL = 4'b0001;
  localparam logic [3:0] CTRL_SRA = 4'b0010;
  localparam logic [3:0] CTRL_ADD = 4'b0011;
  localparam logic [3:0] CTRL_SUB = 4'b0100;
  localparam logic [3:0] CTRL_AND = 4'b0101;
  localparam logic [3:0] CTRL_OR  = 4'b0110;
  localparam logic [3:0] CTRL_XOR = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1000;
  localparam logic [3:0] CTRL_SLT = 4'b1001;
  localparam logic [3:0] CTRL_LUI = 4'b1010;
  localparam logic [3:0] CTRL_NOP = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    logic [3:0]               ctrl;
    logic [ALU_XLEN-1:0]      op1;
    logic [ALU_XLEN-1:0]      op2;
    logic [ALU_REG_IDX_W-1:0] rd_idx;
    logic                     illegal;
  } alu_issue_t;

  // CTRL_NOP doubles as the "unrecognised funct" marker.
  function automatic logic [3:0] funct_ctrl(input logic [5:0] funct);
    case (funct)
      FN_SLL, FN_SLLV: return CTRL_SLL;
      FN_SRL, FN_SRLV: return CTRL_SRL;
      FN_SRA, FN_SRAV: return CTRL_SRA;
      FN_ADDU:         return CTRL_ADD;
      FN_SUBU:         return CTRL_SUB;
      FN_AND:          return CTRL_AND;
      FN_OR:           return CTRL_OR;
      FN_XOR:          return CTRL_XOR;
      FN_NOR:          return CTRL_NOR;
      FN_SLTU:         return CTRL_SLT;
      default:         return CTRL_NOP;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// ============================================================================
// alu_issue_stage_if: instruction-in, write-back and ALU-bundle-out signals.
// Rev 1.0
// ============================================================================
interface alu_issue_stage_if #(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [5:0]           in_opcode;
  logic [5:0]           in_funct;
  logic [REG_IDX_W-1:0] in_rs_idx;
  logic [REG_IDX_W-1:0] in_rt_idx;
  logic [REG_IDX_W-1:0] in_rd_idx;
  logic [XLEN-1:0]      in_rs_val;
  logic [XLEN-1:0]      in_rt_val;
  logic [15:0]          in_imm;
  logic [4:0]           in_shamt;
  logic                 wb_en;
  logic [REG_IDX_W-1:0] wb_idx;
  logic [XLEN-1:0]      wb_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           out_ctrl;
  logic [XLEN-1:0]      out_op1;
  logic [XLEN-1:0]      out_op2;
  logic [REG_IDX_W-1:0] out_rd_idx;
  logic                 out_illegal;

  modport slave (
    input  in_valid, in_opcode, in_funct, in_rs_idx, in_rt_idx, in_rd_idx,
           in_rs_val, in_rt_val, in_imm, in_shamt, wb_en, wb_idx, wb_data,
           out_ready,
    output in_ready, out_valid, out_ctrl, out_op1, out_op2, out_rd_idx,
           out_illegal
  );

  modport master (
    output in_valid, in_opcode, in_funct, in_rs_idx, in_rt_idx, in_rd_idx,
           in_rs_val, in_rt_val, in_imm, in_shamt, wb_en, wb_idx, wb_data,
           out_ready,
    input  in_ready, out_valid, out_ctrl, out_op1, out_op2, out_rd_idx,
           out_illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_decode.sv
`default_nettype none
// ============================================================================
// alu_issue_decode: combinational opcode/funct to ALU ctrl and operand select.
// Rev 1.0
// ============================================================================
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [5:0]               opcode_i,
  input  logic [5:0]               funct_i,
  input  logic [ALU_REG_IDX_W-1:0] rt_idx_i,
  input  logic [ALU_REG_IDX_W-1:0] rd_idx_i,
  input  logic [ALU_XLEN-1:0]      rs_val_i,
  input  logic [ALU_XLEN-1:0]      rt_val_i,
  input  logic [15:0]              imm_i,
  input  logic [4:0]               shamt_i,
  output alu_issue_t               issue_o
);

  logic [3:0]          w_fn_ctrl;
  logic [ALU_XLEN-1:0] w_imm_sext;
  logic [ALU_XLEN-1:0] w_imm_zext;
  logic [ALU_XLEN-1:0] w_shamt_zext;

  assign w_fn_ctrl    = funct_ctrl(funct_i);
  assign w_imm_sext   = {{(ALU_XLEN-16){imm_i[15]}}, imm_i};
  assign w_imm_zext   = {{(ALU_XLEN-16){1'b0}}, imm_i};
  assign w_shamt_zext = {{(ALU_XLEN-5){1'b0}}, shamt_i};

  always_comb begin
    issue_o         = '0;
    issue_o.ctrl    = CTRL_NOP;
    issue_o.illegal = 1'b1;
    case (opcode_i)
      OP_RTYPE: begin
        if (w_fn_ctrl != CTRL_NOP) begin
          issue_o.ctrl    = w_fn_ctrl;
          issue_o.illegal = 1'b0;
          issue_o.rd_idx  = rd_idx_i;
          // Valid shift functs have bit 5 clear; bit 2 selects the variable form.
          if (!funct_i[5]) begin
            issue_o.op1 = rt_val_i;
            issue_o.op2 = funct_i[2] ? rs_val_i : w_shamt_zext;
          end else begin
            issue_o.op1 = rs_val_i;
            issue_o.op2 = rt_val_i;
          end
        end
      end
      OP_ADDIU, OP_SLTIU: begin
        issue_o.ctrl    = (opcode_i == OP_ADDIU) ? CTRL_ADD : CTRL_SLT;
        issue_o.illegal = 1'b0;
        issue_o.rd_idx  = rt_idx_i;
        issue_o.op1     = rs_val_i;
        issue_o.op2     = w_imm_sext;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        issue_o.ctrl    = (opcode_i == OP_ANDI) ? CTRL_AND :
                          (opcode_i == OP_ORI)  ? CTRL_OR  : CTRL_XOR;
        issue_o.illegal = 1'b0;
        issue_o.rd_idx  = rt_idx_i;
        issue_o.op1     = rs_val_i;
        issue_o.op2     = w_imm_zext;
      end
      OP_LUI: begin
        issue_o.ctrl    = CTRL_LUI;
        issue_o.illegal = 1'b0;
        issue_o.rd_idx  = rt_idx_i;
        issue_o.op1     = w_imm_zext;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// alu_issue_stage: forwarding, decode and 2-entry skid buffer ahead of the ALU.
// Rev 1.0
// ============================================================================
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN      = ALU_XLEN,
  parameter int REG_IDX_W = ALU_REG_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_stage_if.slave  bus
);

  logic [XLEN-1:0] w_rs_fwd;
  logic [XLEN-1:0] w_rt_fwd;
  alu_issue_t      w_issue;
  logic            w_accept;
  logic            w_drain;

  alu_issue_t main_q, main_d;
  alu_issue_t skid_q, skid_d;
  logic       main_valid_q, main_valid_d;
  logic       skid_valid_q, skid_valid_d;

  // Index 0 is hardwired zero; a matching non-zero write-back wins over the RF.
  assign w_rs_fwd = (bus.in_rs_idx == '0) ? '0 :
                    (bus.wb_en && (bus.wb_idx == bus.in_rs_idx)) ? bus.wb_data :
                    bus.in_rs_val;
  assign w_rt_fwd = (bus.in_rt_idx == '0) ? '0 :
                    (bus.wb_en && (bus.wb_idx == bus.in_rt_idx)) ? bus.wb_data :
                    bus.in_rt_val;

  alu_issue_decode u_decode (
    .opcode_i (bus.in_opcode),
    .funct_i  (bus.in_funct),
    .rt_idx_i (bus.in_rt_idx),
    .rd_idx_i (bus.in_rd_idx),
    .rs_val_i (w_rs_fwd),
    .rt_val_i (w_rt_fwd),
    .imm_i    (bus.in_imm),
    .shamt_i  (bus.in_shamt),
    .issue_o  (w_issue)
  );

  assign w_accept = bus.in_valid && !skid_valid_q;
  assign w_drain  = main_valid_q && bus.out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (w_drain) begin
      // in_ready is low whenever skid holds data, so accept cannot coincide here.
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (w_accept) begin
        main_d = w_issue;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      if (main_valid_q) begin
        skid_d       = w_issue;
        skid_valid_d = 1'b1;
      end else begin
        main_d       = w_issue;
        main_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.in_ready    = !skid_valid_q;
  assign bus.out_valid   = main_valid_q;
  assign bus.out_ctrl    = main_q.ctrl;
  assign bus.out_op1     = main_q.op1;
  assign bus.out_op2     = main_q.op2;
  assign bus.out_rd_idx  = main_q.rd_idx;
  assign bus.out_illegal = main_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// tb_alu_issue_stage: directed vector table plus backpressure and reset runs.
// Rev 1.0
// ============================================================================
module tb_alu_issue_stage;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rsv;
    logic [31:0] rtv;
    logic [15:0] imm;
    logic [4:0]  sh;
    logic        wb_en;
    logic [4:0]  wb_idx;
    logic [31:0] wb_data;
    logic [3:0]  e_ctrl;
    logic [31:0] e_op1;
    logic [31:0] e_op2;
    logic [4:0]  e_rd;
    logic        e_ill;
    logic        chk_ops;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  alu_issue_stage_if #(.XLEN(32), .REG_IDX_W(5)) bus ();

  alu_issue_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.in_valid  = 1'b0;
    bus.in_opcode = '0;
    bus.in_funct  = '0;
    bus.in_rs_idx = '0;
    bus.in_rt_idx = '0;
    bus.in_rd_idx = '0;
    bus.in_rs_val = '0;
    bus.in_rt_val = '0;
    bus.in_imm    = '0;
    bus.in_shamt  = '0;
    bus.wb_en     = 1'b0;
    bus.wb_idx    = '0;
    bus.wb_data   = '0;
  endtask

  // ADDU tagged by k: rd=k+1, op1=100+k, op2=200+k.
  task automatic drive_bp(input int k);
    bus.in_opcode = 6'h00;
    bus.in_funct  = 6'h21;
    bus.in_rs_idx = 5'd1;
    bus.in_rt_idx = 5'd2;
    bus.in_rd_idx = 5'(k + 1);
    bus.in_rs_val = 32'(100 + k);
    bus.in_rt_val = 32'(200 + k);
    bus.wb_en     = 1'b0;
  endtask

  task automatic check_zero_state(input string tag);
    check({tag, " out_valid"},   {31'd0, bus.out_valid},   32'd0);
    check({tag, " in_ready"},    {31'd0, bus.in_ready},    32'd1);
    check({tag, " out_ctrl"},    {28'd0, bus.out_ctrl},    32'd0);
    check({tag, " out_op1"},     bus.out_op1,              32'd0);
    check({tag, " out_op2"},     bus.out_op2,              32'd0);
    check({tag, " out_rd_idx"},  {27'd0, bus.out_rd_idx},  32'd0);
    check({tag, " out_illegal"}, {31'd0, bus.out_illegal}, 32'd0);
  endtask

  vec_t vecs[15];
  int   idx;
  int   n_got;
  int   seen;
  logic acc;
  logic [4:0]  got_rd[4];
  logic [31:0] got_op1[4];
  logic [31:0] got_op2[4];

  initial begin
    errors = 0;
    checks = 0;
    //          op     fn     rs  rt  rd  rsv           rtv           imm       sh  wb wbi wbd        ctrl   op1           op2           rd  ill chk
    vecs[0]  = '{6'h00, 6'h21, 5,  6,  3,  32'd7,        32'd9,        16'h0000, 0,  0, 0, 32'h0,     4'h3, 32'd7,        32'd9,        3,  0,  1};
    vecs[1]  = '{6'h09, 6'h00, 1,  4,  0,  32'h10,       32'h0,        16'hFFFF, 0,  0, 0, 32'h0,     4'h3, 32'h10,       32'hFFFFFFFF, 4,  0,  1};
    vecs[2]  = '{6'h0C, 6'h00, 1,  7,  0,  32'h12345678, 32'h0,        16'hFFFF, 0,  0, 0, 32'h0,     4'h5, 32'h12345678, 32'h0000FFFF, 7,  0,  1};
    vecs[3]  = '{6'h00, 6'h21, 5,  6,  3,  32'd1,        32'd2,        16'h0000, 0,  1, 5, 32'hDEAD,  4'h3, 32'hDEAD,     32'd2,        3,  0,  1};
    vecs[4]  = '{6'h00, 6'h21, 0,  6,  3,  32'h55,       32'd2,        16'h0000, 0,  1, 0, 32'hDEAD,  4'h3, 32'h0,        32'd2,        3,  0,  1};
    vecs[5]  = '{6'h00, 6'h00, 9,  8,  10, 32'd1,        32'hF0,       16'h0000, 4,  0, 0, 32'h0,     4'h0, 32'hF0,       32'd4,        10, 0,  1};
    vecs[6]  = '{6'h00, 6'h07, 2,  3,  11, 32'd3,        32'h80000000, 16'h0000, 0,  0, 0, 32'h0,     4'h2, 32'h80000000, 32'd3,        11, 0,  1};
    vecs[7]  = '{6'h0F, 6'h00, 1,  12, 0,  32'd99,       32'h0,        16'h1234, 0,  0, 0, 32'h0,     4'hA, 32'h1234,     32'h0,        12, 0,  1};
    vecs[8]  = '{6'h0B, 6'h00, 1,  13, 0,  32'd5,        32'h0,        16'h8000, 0,  0, 0, 32'h0,     4'h9, 32'd5,        32'hFFFF8000, 13, 0,  1};
    vecs[9]  = '{6'h3F, 6'h00, 1,  2,  3,  32'd5,        32'd6,        16'h1234, 0,  0, 0, 32'h0,     4'hF, 32'h0,        32'h0,        0,  1,  0};
    vecs[10] = '{6'h00, 6'h3F, 1,  2,  3,  32'd5,        32'd6,        16'h0000, 0,  0, 0, 32'h0,     4'hF, 32'h0,        32'h0,        0,  1,  0};
    vecs[11] = '{6'h00, 6'h27, 1,  2,  5,  32'hA,        32'hB,        16'h0000, 0,  0, 0, 32'h0,     4'h8, 32'hA,        32'hB,        5,  0,  1};
    vecs[12] = '{6'h0E, 6'h00, 1,  14, 0,  32'd3,        32'h0,        16'h8001, 0,  0, 0, 32'h0,     4'h7, 32'd3,        32'h00008001, 14, 0,  1};
    vecs[13] = '{6'h00, 6'h23, 1,  6,  2,  32'h10,       32'h0,        16'h0000, 0,  1, 6, 32'h77,    4'h4, 32'h10,       32'h77,       2,  0,  1};
    vecs[14] = '{6'h00, 6'h21, 5,  6,  3,  32'd7,        32'd9,        16'h0000, 0,  1, 7, 32'h1111,  4'h3, 32'd7,        32'd9,        3,  0,  1};

    rst_n = 1'b0;
    clear_inputs();
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_zero_state("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero_state("post_reset");

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_opcode = vecs[i].op;
      bus.in_funct  = vecs[i].fn;
      bus.in_rs_idx = vecs[i].rs;
      bus.in_rt_idx = vecs[i].rt;
      bus.in_rd_idx = vecs[i].rd;
      bus.in_rs_val = vecs[i].rsv;
      bus.in_rt_val = vecs[i].rtv;
      bus.in_imm    = vecs[i].imm;
      bus.in_shamt  = vecs[i].sh;
      bus.wb_en     = vecs[i].wb_en;
      bus.wb_idx    = vecs[i].wb_idx;
      bus.wb_data   = vecs[i].wb_data;
      check($sformatf("v%0d in_ready", i), {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("v%0d ctrl", i), {28'd0, bus.out_ctrl}, {28'd0, vecs[i].e_ctrl});
      if (vecs[i].chk_ops) begin
        check($sformatf("v%0d op1", i), bus.out_op1, vecs[i].e_op1);
        check($sformatf("v%0d op2", i), bus.out_op2, vecs[i].e_op2);
      end
      check($sformatf("v%0d rd", i), {27'd0, bus.out_rd_idx}, {27'd0, vecs[i].e_rd});
      check($sformatf("v%0d illegal", i), {31'd0, bus.out_illegal}, {31'd0, vecs[i].e_ill});
    end
    @(negedge clk);
    clear_inputs();
    repeat (2) @(negedge clk);
    check("idle out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure: fill main and skid, stall, then drain all four in order.
    bus.out_ready = 1'b0;
    idx   = 0;
    n_got = 0;
    drive_bp(0);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c >= 3 && c <= 5) begin
        check($sformatf("stall%0d out_valid", c), {31'd0, bus.out_valid}, 32'd1);
        check($sformatf("stall%0d in_ready", c), {31'd0, bus.in_ready}, 32'd0);
        check($sformatf("stall%0d rd", c), {27'd0, bus.out_rd_idx}, 32'd1);
        check($sformatf("stall%0d op1", c), bus.out_op1, 32'd100);
        check($sformatf("stall%0d op2", c), bus.out_op2, 32'd200);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (n_got < 4) begin
          got_rd[n_got]  = bus.out_rd_idx;
          got_op1[n_got] = bus.out_op1;
          got_op2[n_got] = bus.out_op2;
        end
        n_got++;
      end
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 4) drive_bp(idx);
        else bus.in_valid = 1'b0;
      end
      bus.out_ready = (c >= 5);
      @(negedge clk);
    end
    check("bp count", 32'(n_got), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < n_got) begin
        check($sformatf("bp%0d rd", k), {27'd0, got_rd[k]}, 32'(k + 1));
        check($sformatf("bp%0d op1", k), got_op1[k], 32'(100 + k));
        check($sformatf("bp%0d op2", k), got_op2[k], 32'(200 + k));
      end
    end

    // Asynchronous reset with both entries full.
    bus.out_ready = 1'b0;
    drive_bp(0);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    drive_bp(1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("full in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("full out_valid", {31'd0, bus.out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_state("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("after_rst emerged", 32'(seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
